adder_4bit: RTL and testbench

Registered 4-bit ripple-carry adder with carry-in, carry-out and status flags. Sums two 4-bit unsigned operands plus a carry-in and presents the result one clock later with a valid strobe. It is a leaf arithmetic block for datapaths that need a clocked, flag-producing add stage. It also serves as the reference combinational-logic exercise for the team's ripple-carry full-adder chain.

---
 rtl/adder_4bit.sv | 86 ++++++++
 tb/tb_adder_4bit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/adder_4bit.sv
// Registered 4-bit ripple-carry adder with carry-out, zero flag and a valid strobe.
// Define ADDER_4BIT_OVERFLOW_EN to add the registered signed-overflow output V.
module adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       in_valid,
  output logic [3:0] S,
  output logic       Cout,
  output logic       Z,
  output logic       out_valid
`ifdef ADDER_4BIT_OVERFLOW_EN
  ,
  output logic       V
`endif
);

  localparam int DATA_W = 4;

  // Chained full adders. The result is packed as {c[DATA_W-1], c[DATA_W], s}.
  // c[DATA_W-1] is the carry into the sign bit, which is needed for overflow.
  function automatic logic [DATA_W+1:0] ripple_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              ci);
    logic [DATA_W:0]   c;
    logic [DATA_W-1:0] s;
    c[0] = ci;
    for (int i = 0; i < DATA_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[DATA_W-1], c[DATA_W], s};
  endfunction

  logic [DATA_W+1:0] sum_c;
  logic [DATA_W-1:0] s_p0;
  logic              cout_p0;
  logic              z_p0;
  logic              vld_p0;

  always_comb begin
    sum_c = ripple_add(A, B, Cin);
  end

  // ---- stage p0: result registers, loaded only on valid input ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0    <= '0;
      cout_p0 <= 1'b0;
      z_p0    <= 1'b1;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        s_p0    <= sum_c[DATA_W-1:0];
        cout_p0 <= sum_c[DATA_W];
        z_p0    <= ~|sum_c[DATA_W-1:0];
      end
    end
  end

`ifdef ADDER_4BIT_OVERFLOW_EN
  logic v_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_p0 <= 1'b0;
    end else if (in_valid) begin
      v_p0 <= sum_c[DATA_W+1] ^ sum_c[DATA_W];
    end
  end

  assign V = v_p0;
`else
  logic unused_c3;
  assign unused_c3 = sum_c[DATA_W+1];
`endif

  assign S         = s_p0;
  assign Cout      = cout_p0;
  assign Z         = z_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_adder_4bit.sv
// Directed self-checking bench for adder_4bit; expected values are hand-computed
// or taken from the plain integer sum A+B+Cin.
module tb_adder_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [3:0] s;
  logic       cout, z, out_valid;
`ifdef ADDER_4BIT_OVERFLOW_EN
  logic       v;
`endif

  int passes = 0;
  int total  = 0;

  adder_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .in_valid  (in_valid),
    .S         (s),
    .Cout      (cout),
    .Z         (z),
    .out_valid (out_valid)
`ifdef ADDER_4BIT_OVERFLOW_EN
    ,
    .V         (v)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one input set on the falling edge, then sample just after the rising edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic tv);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] es, input logic ec,
                         input logic ez, input logic ev);
    chk({tag, "_s"}, {4'h0, s}, {4'h0, es});
    chk({tag, "_cout"}, {7'h0, cout}, {7'h0, ec});
    chk({tag, "_z"}, {7'h0, z}, {7'h0, ez});
    chk({tag, "_vld"}, {7'h0, out_valid}, 8'h01);
`ifdef ADDER_4BIT_OVERFLOW_EN
    chk({tag, "_v"}, {7'h0, v}, {7'h0, ev});
`else
    if (ev === 1'bx) $display("unexpected X overflow expectation in %s", tag);
`endif
  endtask

  initial begin
    rst = 1'b1;
    a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    #1;
    chk("rst_s", {4'h0, s}, 8'h00);
    chk("rst_cout", {7'h0, cout}, 8'h00);
    chk("rst_z", {7'h0, z}, 8'h01);
    chk("rst_vld", {7'h0, out_valid}, 8'h00);
`ifdef ADDER_4BIT_OVERFLOW_EN
    chk("rst_v", {7'h0, v}, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // basic vectors
    step(4'b0000, 4'b0000, 1'b0, 1'b1); chk_vec("b0", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 1'b1); chk_vec("b1", 4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0110, 4'b0101, 1'b0, 1'b1); chk_vec("b2", 4'b1011, 1'b0, 1'b0, 1'b1);
    // carry vectors
    step(4'b1100, 4'b1010, 1'b1, 1'b1); chk_vec("c0", 4'b0111, 1'b1, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b1); chk_vec("c1", 4'b1111, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 1'b1); chk_vec("c2", 4'b0000, 1'b1, 1'b1, 1'b0);

    // hold: 0101+0011 = 1000, then idle cycles with changing inputs
    step(4'b0101, 4'b0011, 1'b0, 1'b1); chk_vec("h0", 4'b1000, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("hold1_s", {4'h0, s}, 8'h08);
    chk("hold1_cout", {7'h0, cout}, 8'h00);
    chk("hold1_vld", {7'h0, out_valid}, 8'h00);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("hold2_s", {4'h0, s}, 8'h08);
    chk("hold2_z", {7'h0, z}, 8'h00);
    chk("hold2_vld", {7'h0, out_valid}, 8'h00);

    // exhaustive back-to-back
    for (int i = 0; i < 512; i++) begin
      logic [4:0] exp_sum;
      exp_sum = 5'(i[8:5]) + 5'(i[4:1]) + 5'(i[0]);
      step(i[8:5], i[4:1], i[0], 1'b1);
      chk("ex_sum", {3'h0, cout, s}, {3'h0, exp_sum});
      chk("ex_vld", {7'h0, out_valid}, 8'h01);
    end

    // reset mid-stream
    step(4'b0010, 4'b0011, 1'b0, 1'b1); chk_vec("m0", 4'b0101, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 4'b0111; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mrst_s", {4'h0, s}, 8'h00);
    chk("mrst_cout", {7'h0, cout}, 8'h00);
    chk("mrst_z", {7'h0, z}, 8'h01);
    chk("mrst_vld", {7'h0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("mrst_hold_vld", {7'h0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_vec("m1", 4'b1000, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
